// File: rtl/vga_sync_gen.sv
//------------------------------------------------------------------------------
// vga_sync_gen
//
// Timing generator for 640x480@60 Hz VGA on the DE10-Lite. It runs from the
// 50 MHz board clock and derives a divide-by-2 pixel clock enable. It feeds the
// pixel/colour stage with the current pixel coordinate and a request strobe.
// HS, VS and display-enable are delayed by PIPE_DELAY pixel ticks, so they
// leave the FPGA aligned with the colour stage's registered RGB outputs.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixels (640/16/96/48)
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines    (480/10/2/33)
//   SYNC_POL                   active level of HS/VS (0 = active-low)
//   PIPE_DELAY                 pixel ticks of delay on HS/VS/de, 0..7
//   H_TOTAL and V_TOTAL must both be <= 1024 (the counters are 10 bits).
//
// Ports
//   MAX10_CLK1_50  in   50 MHz clock; all logic on the rising edge
//   rst_n          in   asynchronous active-low reset
//   pix_ce         out  pixel clock enable, high on every second clock
//   x              out  horizontal count, 0..H_TOTAL-1
//   y              out  vertical count,   0..V_TOTAL-1
//   req            out  (x,y) is visible and the generator is running
//   line_start     out  one-clock pulse at x==0 on a pix_ce cycle
//   frame_start    out  one-clock pulse at (x,y)==(0,0) on a pix_ce cycle
//   VGA_HS         out  horizontal sync, delayed PIPE_DELAY pixel ticks
//   VGA_VS         out  vertical sync,   delayed PIPE_DELAY pixel ticks
//   de             out  display enable (req delayed PIPE_DELAY pixel ticks)
//------------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst_n,
  output logic       pix_ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       req,
  output logic       line_start,
  output logic       frame_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       de
);

  //----------------------------------------------------------------------------
  // Derived timing constants
  //----------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count values before wrap.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits wide. A sync pulse may end exactly at 1024
  // when the back porch is zero, and that end value must not truncate to 0.
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  //----------------------------------------------------------------------------
  // State
  //----------------------------------------------------------------------------
  logic       r_run;      // cleared by reset, set on the first edge after it
  logic       r_pix_ce;   // divide-by-2 toggle
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_h_vis;
  logic        w_v_vis;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_req_raw;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_line_start;

  //----------------------------------------------------------------------------
  // Run flag and pixel clock enable
  //
  // The toggle leaves reset at 0, so its first edge after release sets it to
  // 1. That is the same edge that sets r_run. The run flag therefore starts
  // on a pix_ce cycle, and the counters first step on the edge after it.
  //----------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) assignments. Every register
  // then samples pre-edge values, regardless of the order the blocks run in.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_pix_ce <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_pix_ce <= ~r_pix_ce;
    end
  end

  //----------------------------------------------------------------------------
  // Raster counters: they step only on edges that end a pix_ce cycle, so each
  // (x,y) is held for exactly two clocks.
  //----------------------------------------------------------------------------
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_pix_ce) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        // On the bottom-right pixel both counters wrap on the same edge.
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Undelayed decode of the current raster position
  //----------------------------------------------------------------------------
  assign w_h_ext   = {1'b0, r_h_cnt};
  assign w_v_ext   = {1'b0, r_v_cnt};

  assign w_h_vis   = (w_h_ext < H_VIS_END);
  assign w_v_vis   = (w_v_ext < V_VIS_END);
  assign w_hs_act  = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
  assign w_vs_act  = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);

  assign w_req_raw = r_run && w_h_vis && w_v_vis;
  assign w_hs_raw  = w_hs_act ? SYNC_POL : ~SYNC_POL;
  assign w_vs_raw  = w_vs_act ? SYNC_POL : ~SYNC_POL;

  // These strobes are qualified by pix_ce. Each one therefore lasts a single
  // clock, even though x==0 is held for two clocks.
  assign w_line_start = r_pix_ce && r_run && (r_h_cnt == 10'd0);

  assign pix_ce      = r_pix_ce;
  assign x           = r_h_cnt;
  assign y           = r_v_cnt;
  assign req         = w_req_raw;
  assign line_start  = w_line_start;
  assign frame_start = w_line_start && (r_v_cnt == 10'd0);

  //----------------------------------------------------------------------------
  // Output delay line
  //
  // Stage 0 captures the raw levels on the edge that ends their pix_ce
  // cycle. Each further stage adds one pixel tick (two clocks), so the pins
  // lag the counters by exactly 2*PIPE_DELAY clocks.
  //----------------------------------------------------------------------------
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign VGA_HS = w_hs_raw;
    assign VGA_VS = w_vs_raw;
    assign de     = w_req_raw;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] r_hs_pipe;
    logic [PIPE_DELAY-1:0] r_vs_pipe;
    logic [PIPE_DELAY-1:0] r_de_pipe;

    // NOTE: unlike a data RAM, every stage of this shift register is reset.
    // Stale stages would otherwise replay a fragment of the old frame's sync
    // pulse after a mid-frame reset.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
      if (!rst_n) begin
        r_hs_pipe <= {PIPE_DELAY{~SYNC_POL}};
        r_vs_pipe <= {PIPE_DELAY{~SYNC_POL}};
        r_de_pipe <= '0;
      end else if (r_pix_ce) begin
        r_hs_pipe[0] <= w_hs_raw;
        r_vs_pipe[0] <= w_vs_raw;
        r_de_pipe[0] <= w_req_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          r_hs_pipe[i] <= r_hs_pipe[i-1];
          r_vs_pipe[i] <= r_vs_pipe[i-1];
          r_de_pipe[i] <= r_de_pipe[i-1];
        end
      end
    end

    assign VGA_HS = r_hs_pipe[PIPE_DELAY-1];
    assign VGA_VS = r_vs_pipe[PIPE_DELAY-1];
    assign de     = r_de_pipe[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
//------------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Three builds of vga_sync_gen share one clock, and each has its own reset:
//   u_def  default 640x480 timing: reset, cadence, horizontal timing.
//   u_vt   default horizontal timing with a short 8-line frame
//          (V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1). It covers frame period,
//          VS placement, de per frame and a reset in mid VS pulse, within a
//          short run.
//   u_sm   the small build (12-pixel line, 7-line frame, SYNC_POL=1,
//          PIPE_DELAY=0).
// Cycle index k counts clock edges after reset release. k=1 is the first
// edge, where run and pix_ce rise. Outputs are sampled on the falling edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_def, rst_n_vt, rst_n_sm;

  logic       d_pce, d_req, d_ls, d_fs, d_hs, d_vs, d_de;
  logic [9:0] d_x, d_y;
  logic       t_pce, t_req, t_ls, t_fs, t_hs, t_vs, t_de;
  logic [9:0] t_x, t_y;
  logic       s_pce, s_req, s_ls, s_fs, s_hs, s_vs, s_de;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_def (
    .MAX10_CLK1_50(clk), .rst_n(rst_n_def), .pix_ce(d_pce), .x(d_x), .y(d_y),
    .req(d_req), .line_start(d_ls), .frame_start(d_fs),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .de(d_de)
  );

  vga_sync_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_vt (
    .MAX10_CLK1_50(clk), .rst_n(rst_n_vt), .pix_ce(t_pce), .x(t_x), .y(t_y),
    .req(t_req), .line_start(t_ls), .frame_start(t_fs),
    .VGA_HS(t_hs), .VGA_VS(t_vs), .de(t_de)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) u_sm (
    .MAX10_CLK1_50(clk), .rst_n(rst_n_sm), .pix_ce(s_pce), .x(s_x), .y(s_y),
    .req(s_req), .line_start(s_ls), .frame_start(s_fs),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .de(s_de)
  );

  typedef struct {
    int k;
    int x;
    int y;
    bit pce, req, ls, fs, hs, vs, de;
  } vec_t;

  typedef struct {
    logic       pce, req, ls, fs, hs, vs, de;
    logic [9:0] x, y;
  } obs_t;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // flags = {pce, req, line_start, frame_start, hs, vs, de}
  function automatic vec_t mk(input int k, input int x, input int y, input bit [6:0] f);
    vec_t v;
    v.k = k; v.x = x; v.y = y;
    v.pce = f[6]; v.req = f[5]; v.ls = f[4]; v.fs = f[3];
    v.hs = f[2];  v.vs = f[1];  v.de = f[0];
    return v;
  endfunction

  function automatic obs_t obs_def();
    obs_t o;
    o.pce = d_pce; o.req = d_req; o.ls = d_ls; o.fs = d_fs;
    o.hs = d_hs; o.vs = d_vs; o.de = d_de; o.x = d_x; o.y = d_y;
    return o;
  endfunction

  function automatic obs_t obs_sm();
    obs_t o;
    o.pce = s_pce; o.req = s_req; o.ls = s_ls; o.fs = s_fs;
    o.hs = s_hs; o.vs = s_vs; o.de = s_de; o.x = s_x; o.y = s_y;
    return o;
  endfunction

  task automatic check_vec(input string tag, input vec_t v, input obs_t o);
    string p;
    p = $sformatf("%s k=%0d", tag, v.k);
    check({p, " x"},           32'(o.x),   32'(v.x));
    check({p, " y"},           32'(o.y),   32'(v.y));
    check({p, " pix_ce"},      32'(o.pce), 32'(v.pce));
    check({p, " req"},         32'(o.req), 32'(v.req));
    check({p, " line_start"},  32'(o.ls),  32'(v.ls));
    check({p, " frame_start"}, 32'(o.fs),  32'(v.fs));
    check({p, " VGA_HS"},      32'(o.hs),  32'(v.hs));
    check({p, " VGA_VS"},      32'(o.vs),  32'(v.vs));
    check({p, " de"},          32'(o.de),  32'(v.de));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  vec_t def_tab[16];
  vec_t sm_tab[17];

  initial begin
    int x_err, y_err, ce_err, hs_low, hs_first, de_hi, ls_cnt;
    int fs1, fs2, vs_low, vs_first, vs_last, vs_y, de_clk, de_tick;
    int rq_de_err, hs_x_err, sm_hs_hi, sm_ls_cnt, sm_fs_cnt, sm_ls2;

    // Default build; HS/VS active-low, PIPE_DELAY=2 (lag of 4 clocks).
    def_tab[0]  = mk(   1,   0, 0, 7'b1111110);
    def_tab[1]  = mk(   2,   1, 0, 7'b0100110);
    def_tab[2]  = mk(   3,   1, 0, 7'b1100110);
    def_tab[3]  = mk(   4,   2, 0, 7'b0100111);
    def_tab[4]  = mk(1279, 639, 0, 7'b1100111);
    def_tab[5]  = mk(1280, 640, 0, 7'b0000111);
    def_tab[6]  = mk(1283, 641, 0, 7'b1000111);
    def_tab[7]  = mk(1284, 642, 0, 7'b0000110);
    def_tab[8]  = mk(1315, 657, 0, 7'b1000110);
    def_tab[9]  = mk(1316, 658, 0, 7'b0000010);
    def_tab[10] = mk(1507, 753, 0, 7'b1000010);
    def_tab[11] = mk(1508, 754, 0, 7'b0000110);
    def_tab[12] = mk(1599, 799, 0, 7'b1000110);
    def_tab[13] = mk(1600,   0, 1, 7'b0100110);
    def_tab[14] = mk(1601,   0, 1, 7'b1110110);
    def_tab[15] = mk(1604,   2, 1, 7'b0100111);

    // Small build: 12-pixel line, 7-line frame, active-high sync, no delay.
    sm_tab[0]  = mk(  1,  0, 0, 7'b1111001);
    sm_tab[1]  = mk(  2,  1, 0, 7'b0100001);
    sm_tab[2]  = mk( 15,  7, 0, 7'b1100001);
    sm_tab[3]  = mk( 16,  8, 0, 7'b0000000);
    sm_tab[4]  = mk( 18,  9, 0, 7'b0000100);
    sm_tab[5]  = mk( 21, 10, 0, 7'b1000100);
    sm_tab[6]  = mk( 22, 11, 0, 7'b0000000);
    sm_tab[7]  = mk( 23, 11, 0, 7'b1000000);
    sm_tab[8]  = mk( 24,  0, 1, 7'b0100001);
    sm_tab[9]  = mk( 25,  0, 1, 7'b1110001);
    sm_tab[10] = mk( 96,  0, 4, 7'b0000000);
    sm_tab[11] = mk(120,  0, 5, 7'b0000010);
    sm_tab[12] = mk(143, 11, 5, 7'b1000010);
    sm_tab[13] = mk(144,  0, 6, 7'b0000000);
    sm_tab[14] = mk(167, 11, 6, 7'b1000000);
    sm_tab[15] = mk(168,  0, 0, 7'b0100001);
    sm_tab[16] = mk(169,  0, 0, 7'b1111001);

    rst_n_def = 1'b0;
    rst_n_vt  = 1'b0;
    rst_n_sm  = 1'b0;
    repeat (5) tick();

    // ---------------- Reset state ----------------
    check("reset def VGA_HS", 32'(d_hs), 32'd1);
    check("reset def VGA_VS", 32'(d_vs), 32'd1);
    check("reset def de",     32'(d_de), 32'd0);
    check("reset def x",      32'(d_x),  32'd0);
    check("reset def y",      32'(d_y),  32'd0);
    check("reset def pix_ce", 32'(d_pce), 32'd0);
    check("reset def req",    32'(d_req), 32'd0);
    check("reset def line_start",  32'(d_ls), 32'd0);
    check("reset def frame_start", 32'(d_fs), 32'd0);
    check("reset sm VGA_HS (active-high build)", 32'(s_hs), 32'd0);
    check("reset sm VGA_VS (active-high build)", 32'(s_vs), 32'd0);

    // ---------------- Default build: two full lines ----------------
    rst_n_def = 1'b1;
    x_err = 0; y_err = 0; ce_err = 0;
    hs_low = 0; hs_first = 0; de_hi = 0; ls_cnt = 0;
    for (int k = 1; k <= 3200; k++) begin
      tick();
      for (int i = 0; i < $size(def_tab); i++)
        if (def_tab[i].k == k) check_vec("def", def_tab[i], obs_def());
      if (d_x !== 10'((k / 2) % 800)) x_err++;
      if (d_y !== 10'(k / 1600))      y_err++;
      if (d_pce !== 1'(k % 2))        ce_err++;
      if (k >= 1600) begin
        if (d_hs === 1'b0) begin
          hs_low++;
          if (hs_first == 0) hs_first = k;
        end
        if (d_de === 1'b1) de_hi++;
        if (d_ls === 1'b1) ls_cnt++;
      end
    end
    check("def x cadence errors",       32'(x_err),  32'd0);
    check("def y cadence errors",       32'(y_err),  32'd0);
    check("def pix_ce cadence errors",  32'(ce_err), 32'd0);
    check("def line1 HS low clocks",    32'(hs_low), 32'd192);
    check("def line1 HS fall clock",    32'(hs_first), 32'd2916);
    check("def line1 de high clocks",   32'(de_hi),  32'd1280);
    check("def line1 line_start count", 32'(ls_cnt), 32'd1);

    // ---------------- Short-frame build: vertical timing ----------------
    // Frame = 8 lines = 12800 clocks; VS lines 5..6 -> low k=8004..11203.
    rst_n_vt = 1'b1;
    fs1 = 0; fs2 = 0; vs_low = 0; vs_first = 0; vs_last = 0; vs_y = -1;
    de_clk = 0; de_tick = 0;
    for (int k = 1; k <= 23800; k++) begin
      tick();
      if (t_fs === 1'b1) begin
        if (fs1 == 0) fs1 = k;
        else if (fs2 == 0) fs2 = k;
      end
      if (k <= 12800) begin
        if (t_vs === 1'b0) begin
          vs_low++;
          vs_last = k;
          if (vs_first == 0) begin
            vs_first = k;
            vs_y = int'(t_y);
          end
        end
        if (t_de === 1'b1) begin
          de_clk++;
          if (t_pce === 1'b1) de_tick++;
        end
      end
    end
    check("vt first frame_start clock",  32'(fs1),      32'd1);
    check("vt second frame_start clock", 32'(fs2),      32'd12801);
    check("vt VS low clocks per frame",  32'(vs_low),   32'd3200);
    check("vt VS fall clock",            32'(vs_first), 32'd8004);
    check("vt VS last low clock",        32'(vs_last),  32'd11203);
    check("vt y at VS fall",             32'(vs_y),     32'd5);
    check("vt de high clocks per frame", 32'(de_clk),   32'd5120);
    check("vt de pixel ticks per frame", 32'(de_tick),  32'd2560);

    // Mid-frame reset at (700, 6) while both syncs are low.
    check("vt pre-reset x",      32'(t_x),  32'd700);
    check("vt pre-reset y",      32'(t_y),  32'd6);
    check("vt pre-reset VGA_VS", 32'(t_vs), 32'd0);
    check("vt pre-reset VGA_HS", 32'(t_hs), 32'd0);
    rst_n_vt = 1'b0;
    #1;
    check("vt async reset VGA_VS", 32'(t_vs),  32'd1);
    check("vt async reset VGA_HS", 32'(t_hs),  32'd1);
    check("vt async reset de",     32'(t_de),  32'd0);
    check("vt async reset req",    32'(t_req), 32'd0);
    check("vt async reset x",      32'(t_x),   32'd0);
    check("vt async reset y",      32'(t_y),   32'd0);
    repeat (3) tick();
    rst_n_vt = 1'b1;
    vs_low = 0;
    for (int k = 1; k <= 8004; k++) begin
      tick();
      if (k == 1) begin
        check("vt restart frame_start", 32'(t_fs), 32'd1);
        check("vt restart req",         32'(t_req), 32'd1);
      end
      if (k < 8004 && t_vs !== 1'b1) vs_low++;
    end
    check("vt restart stray VS clocks", 32'(vs_low), 32'd0);
    check("vt restart VS at line 490-equivalent", 32'(t_vs), 32'd0);
    check("vt restart y at VS fall", 32'(t_y), 32'd5);

    // ---------------- Small build ----------------
    rst_n_sm = 1'b1;
    rq_de_err = 0; hs_x_err = 0; sm_hs_hi = 0; sm_ls_cnt = 0; sm_fs_cnt = 0; sm_ls2 = 0;
    for (int k = 1; k <= 170; k++) begin
      tick();
      for (int i = 0; i < $size(sm_tab); i++)
        if (sm_tab[i].k == k) check_vec("sm", sm_tab[i], obs_sm());
      if (s_req !== s_de) rq_de_err++;
      if (s_hs !== ((s_x == 10'd9) || (s_x == 10'd10))) hs_x_err++;
      if (k >= 24 && k <= 47 && s_hs === 1'b1) sm_hs_hi++;
      if (k <= 168) begin
        if (s_ls === 1'b1) begin
          sm_ls_cnt++;
          if (sm_ls_cnt == 2) sm_ls2 = k;
        end
        if (s_fs === 1'b1) sm_fs_cnt++;
      end
    end
    check("sm req/de disagreements",    32'(rq_de_err), 32'd0);
    check("sm HS vs x=9..10 mismatch",  32'(hs_x_err),  32'd0);
    check("sm HS high clocks in line1", 32'(sm_hs_hi),  32'd4);
    check("sm line_starts per frame",   32'(sm_ls_cnt), 32'd7);
    check("sm second line_start clock", 32'(sm_ls2),    32'd25);
    check("sm frame_starts per frame",  32'(sm_fs_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for 640x480@60 Hz VGA on the DE10-Lite, running from the 50 MHz board clock with a divide-by-2 pixel clock enable. It sits directly upstream of the pixel/colour stage that drives VGA_R/G/B. It supplies pixel coordinates and a request strobe to that stage. It also supplies VGA_HS/VGA_VS and a display-enable, delayed by a parameterised number of pixel ticks so they line up with the colour stage's output latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of HS/VS (0 = active-low)
- PIPE_DELAY, 2, pixel ticks of delay applied to VGA_HS/VGA_VS/de; range 0..7
- MAX10_CLK1_50  in  1  50 MHz clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_ce  out  1  pixel clock enable, high every second clock
- x  out  10  current horizontal count (0..H_TOTAL-1)
- y  out  10  current vertical count (0..V_TOTAL-1)
- req  out  1  high while (x,y) is in the visible area and the generator is running
- line_start  out  1  one-clock pulse at x==0 on a pix_ce cycle
- frame_start  out  1  one-clock pulse at (x,y)==(0,0) on a pix_ce cycle
- VGA_HS  out  1  horizontal sync, delayed PIPE_DELAY ticks
- VGA_VS  out  1  vertical sync, delayed PIPE_DELAY ticks
- de  out  1  display enable (req delayed PIPE_DELAY ticks)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤ 1024. Counters are 10 bits, unsigned.
- pix_ce is a toggle flop. A run flag is cleared by reset and set on the first clock edge after rst_n rises. The toggle flop resets to 0 and toggles on every edge while running.
- h_cnt/v_cnt advance only on edges where pix_ce==1.
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps and itself wraps V_TOTAL-1 -> 0.
- x = h_cnt, y = v_cnt. They change only on pix_ce edges.
- req = run && h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- Raw sync levels:
  - hs_raw is active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw is active when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - "Active" means the pin equals SYNC_POL.
- Delay line:
  - hs_raw, vs_raw and req pass through a PIPE_DELAY-deep shift register clocked on pix_ce edges.
  - With PIPE_DELAY=0, the outputs follow the raw values combinationally.
- line_start = pix_ce && run && h_cnt==0. frame_start additionally requires v_cnt==0.

## Timing
- Reset values (asserted asynchronously):
  - pix_ce=0, x=0, y=0, req=0, line_start=0, frame_start=0, de=0.
  - VGA_HS=VGA_VS=~SYNC_POL (inactive).
  - All delay-line stages hold inactive values.
- First clock edge after rst_n rises:
  - run=1 and pix_ce=1, so req=1, line_start=1 and frame_start=1 with (x,y)=(0,0).
  - The counters first advance on the following edge.
- Each (x,y) is held for exactly 2 clocks. A line is 1600 clocks; a frame is 840,000 clocks (16.8 ms).
- VGA_HS/VGA_VS/de lag the raw values by exactly 2*PIPE_DELAY clocks. Each delayed output changes only on the edge ending a pix_ce cycle.
- Simultaneous wraps (h_cnt==799, v_cnt==524): both counters return to 0 on the same edge. frame_start follows in that pix_ce cycle.
- Reset mid-frame: everything returns to reset values immediately. Restart behaves exactly as after power-up, with no partial sync pulse emitted from stale delay-line contents.

## Test plan
- Reset release:
  - Hold rst_n low for 5 clocks, then check VGA_HS=VGA_VS=1, de=0, x=y=0.
  - On the first edge after release, check frame_start=1 for exactly 1 clock and req=1.
- Cadence: pix_ce alternates 1,0 every clock after release. x increments 0,1,2,… every 2 clocks. x wraps 799->0 and y increments at clock 1600.
- Horizontal timing with default parameters:
  - VGA_HS low for exactly 192 clocks per line.
  - Falling edge 2*(656+2)=1316 clocks after line_start.
  - de high for 1280 clocks per visible line.
- Vertical timing:
  - frame_start pulses every 840,000 clocks.
  - VGA_VS low for exactly 3200 clocks starting at line 490, offset by +4 clocks.
  - de-high pixel ticks per frame = 307,200.
- Reset mid-frame: assert rst_n at (x,y)=(700,491) with VGA_VS low. Check VGA_VS=1 and de=0 immediately. Check that the restarted frame's first VS pulse again occurs at line 490.
- Small-parameter build:
  - Settings: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=1, PIPE_DELAY=0.
  - Check a 24-clock line and a 168-clock frame.
  - Check VGA_HS high for 4 clocks on the same edges as x=9..10, and req/de identical.
